cpu_mem_if: RTL and testbench
=============================

Name: cpu_mem_if

Overview:
- Parametrised memory interface for the next-generation CPU.
- Replaces the fixed single-cycle memory port (address, data out, data in, write strobe) with a request/acknowledge bus that tolerates variable-latency memory.
- Adds a posted-write buffer, read-after-write ordering, a bus timeout and a sticky error flag.
- Sits between the CPU core's memory port and the external memory/bus.

Parameters:
- WORD_SIZE, 16, data width in bits
- ADDR_SIZE, 16, address width in bits
- WBUF_DEPTH, 4, posted-write FIFO depth in entries, power of two, >=2
- TIMEOUT, 255, max cycles mem_req may stay unacknowledged; 0 disables the timeout

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU access request, held until accepted
- cpu_write  input  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  input  ADDR_SIZE  access address
- cpu_wdata  input  WORD_SIZE  write data
- cpu_ready  output  1  transfer completes in a cycle where cpu_req and cpu_ready are both high
- cpu_rdata  output  WORD_SIZE  read data, valid when a read completes
- cpu_error  output  1  sticky bus-timeout flag
- error_clr  input  1  clears cpu_error
- wbuf_level  output  clog2(WBUF_DEPTH)+1  current number of buffered writes
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  memory write enable for the current request
- mem_addr  output  ADDR_SIZE  memory address
- mem_wdata  output  WORD_SIZE  memory write data
- mem_ack  input  1  memory completion, single-cycle pulse
- mem_rdata  input  WORD_SIZE  read data, valid with mem_ack

Behaviour:
- Reset (reset low, asynchronous):
  - All of the following are 0: mem_req, mem_we, mem_addr, mem_wdata, cpu_ready, cpu_rdata, cpu_error, wbuf_level.
  - FIFO is emptied, FSM goes to IDLE, timeout counter is cleared.
  - Reset mid-transaction drops mem_req immediately and discards all pending writes.
- Writes (posted):
  - For a write, cpu_ready = (fifo not full) and (FSM not in a read state). This path is combinational.
  - On acceptance, {addr, wdata} is pushed into the FIFO and the CPU proceeds with zero wait.
  - A full FIFO never accepts a write, even if the FIFO pops in the same cycle.
  - A simultaneous push and pop leaves wbuf_level unchanged.
- FSM states: IDLE, WR_BUS, DRAIN, RD_BUS, RD_DONE.
  - IDLE:
    - If a read is pending (cpu_req & !cpu_write): go to DRAIN if the FIFO is non-empty, otherwise go to RD_BUS.
    - Else if the FIFO is non-empty, go to WR_BUS.
    - Reads take priority over starting a new drain, but ordering is preserved by DRAIN.
  - WR_BUS:
    - mem_req=1, mem_we=1, mem_addr/mem_wdata taken from the FIFO head.
    - On mem_ack, pop the FIFO and return to IDLE.
  - DRAIN:
    - Issues writes exactly as WR_BUS does, back-to-back.
    - When the FIFO is empty after an ack, go to RD_BUS.
    - New CPU writes are refused (cpu_ready=0) throughout DRAIN and RD_BUS.
  - RD_BUS:
    - mem_req=1, mem_we=0, mem_addr=cpu_addr, which is registered on entry.
    - On mem_ack, register mem_rdata into cpu_rdata and go to RD_DONE.
  - RD_DONE:
    - cpu_ready=1 for exactly one cycle, cpu_rdata valid; then return to IDLE.
    - cpu_rdata holds its value until the next read completes.
- Read latency: minimum 2 cycles after mem_ack (ack cycle plus RD_DONE). A read issued with an empty FIFO and a memory that acks in the first request cycle completes on the 3rd cycle after cpu_req rises.
- Bus signals:
  - mem_addr, mem_wdata and mem_we are registered outputs.
  - They change only when a new request starts and stay stable while mem_req=1.
  - mem_req deasserts in the cycle after mem_ack.
- Timeout:
  - The counter increments each cycle mem_req=1 without mem_ack and clears on ack or when a new request starts.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT, the request is aborted:
    - mem_req drops next cycle and cpu_error is set.
    - An aborted write is popped.
    - An aborted read completes through RD_DONE with cpu_rdata = all ones.
  - mem_ack arriving in the same cycle as the timeout wins; no error is raised.
- Error flag:
  - cpu_error is sticky and cleared by error_clr.
  - If a set event and error_clr coincide, set wins.
- Stray mem_ack with mem_req=0 is ignored.

Test Plan:
- Reset: assert reset low mid-WR_BUS with 3 writes buffered -> mem_req=0 immediately, wbuf_level=0, cpu_error=0; after release, no bus activity.
- Posted writes: 4 back-to-back writes (0x0010..0x0013, data 0xA000..0xA003) with mem_ack delayed 3 cycles each:
  - cpu_ready high for all 4, wbuf_level reaches 4, 5th write stalls.
  - Memory sees the writes in order, and wbuf_level decrements per ack.
- Read-after-write: write 0x1234 to 0x0040, then immediately read 0x0040, memory returns 0x1234:
  - The write appears on the bus before the read.
  - cpu_ready pulses once with cpu_rdata=0x1234.
- Zero-wait read: empty FIFO, read 0x0005, mem_ack in the first request cycle with 0xBEEF -> cpu_ready on cycle 3, cpu_rdata=0xBEEF.
- Timeout (TIMEOUT=8): read with no mem_ack:
  - mem_req drops after 8 cycles, cpu_error=1, cpu_rdata=0xFFFF, cpu_ready pulses.
  - error_clr clears the flag.
  - Repeat with mem_ack on cycle 8: no error.
- Full-with-pop: FIFO full, an ack pops the head while cpu_req write is high -> write is not accepted that cycle, is accepted the next cycle, wbuf_level=WBUF_DEPTH.

Source files
------------

// File: rtl/cpu_mem_if.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mem_if
// Brief   : CPU request/acknowledge memory port with posted-write FIFO,
//           read-after-write ordering, bus timeout and sticky error flag.
// Rev     : 1.0  initial release
// ============================================================================
module cpu_mem_if #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_SIZE  = 16,
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_req,
    input  logic                        cpu_write,
    input  logic [ADDR_SIZE-1:0]        cpu_addr,
    input  logic [WORD_SIZE-1:0]        cpu_wdata,
    output logic                        cpu_ready,
    output logic [WORD_SIZE-1:0]        cpu_rdata,
    output logic                        cpu_error,
    input  logic                        error_clr,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_level,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_SIZE-1:0]        mem_addr,
    output logic [WORD_SIZE-1:0]        mem_wdata,
    input  logic                        mem_ack,
    input  logic [WORD_SIZE-1:0]        mem_rdata
);
    localparam int c_PTR_W = $clog2(WBUF_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit c_TMO_EN = (TIMEOUT != 0);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_BUS  = 3'd1,
        S_DRAIN   = 3'd2,
        S_RD_BUS  = 3'd3,
        S_RD_DONE = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [ADDR_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_mem_wdata;
    logic [WORD_SIZE-1:0] r_cpu_rdata;
    logic                 r_error;
    logic [c_TMO_W-1:0]   r_tcnt;

    logic [ADDR_SIZE-1:0] r_fifo_addr [0:WBUF_DEPTH-1];
    logic [WORD_SIZE-1:0] r_fifo_data [0:WBUF_DEPTH-1];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_wr_ok;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_pend;
    logic                 w_timeout;
    logic                 w_done;
    logic [ADDR_SIZE-1:0] w_head_addr;
    logic [WORD_SIZE-1:0] w_head_data;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_LVL_W'(WBUF_DEPTH));
    // Writes are refused while a read is being ordered behind the buffer.
    assign w_wr_ok     = cpu_write & ~w_full & ((r_state == S_IDLE) | (r_state == S_WR_BUS));
    assign w_push      = cpu_req & w_wr_ok;
    assign w_rd_pend   = cpu_req & ~cpu_write;
    assign w_timeout   = c_TMO_EN & r_mem_req & ~mem_ack & (r_tcnt == c_TMO_LAST);
    assign w_done      = r_mem_req & (mem_ack | w_timeout);
    assign w_pop       = w_done & ((r_state == S_WR_BUS) | (r_state == S_DRAIN));
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    assign cpu_ready  = reset & ((r_state == S_RD_DONE) | w_push);
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_error  = r_error;
    assign wbuf_level = r_level;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= cpu_addr;
            r_fifo_data[r_wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_error     <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            if (w_timeout)      r_error <= 1'b1;
            else if (error_clr) r_error <= 1'b0;

            if (r_mem_req && !mem_ack) r_tcnt <= r_tcnt + 1'b1;
            else                       r_tcnt <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_rd_pend && w_empty) begin
                        r_state    <= S_RD_BUS;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= cpu_addr;
                    end else if (!w_empty) begin
                        r_state     <= w_rd_pend ? S_DRAIN : S_WR_BUS;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_head_addr;
                        r_mem_wdata <= w_head_data;
                    end
                end
                S_WR_BUS: begin
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                // Between drained writes the bus idles one cycle before the next request.
                S_DRAIN: begin
                    if (!r_mem_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_head_addr;
                        r_mem_wdata <= w_head_data;
                    end else if (w_done) begin
                        r_mem_req <= 1'b0;
                        if (r_level == c_LVL_W'(1)) r_state <= S_RD_BUS;
                    end
                end
                S_RD_BUS: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= cpu_addr;
                    end else if (w_done) begin
                        r_mem_req   <= 1'b0;
                        r_cpu_rdata <= mem_ack ? mem_rdata : '1;
                        r_state     <= S_RD_DONE;
                    end
                end
                S_RD_DONE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_if.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_mem_if
// Brief   : Self-checking bench for cpu_mem_if with a behavioural memory.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_mem_if;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_write, cpu_ready, cpu_error, error_clr;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]  wbuf_level;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cpu_mem_if #(.WORD_SIZE(16), .ADDR_SIZE(16), .WBUF_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_error(cpu_error), .error_clr(error_clr),
        .wbuf_level(wbuf_level),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } bus_t;
    bus_t        bus_log[$];
    bus_t        exp_log[$];
    logic [15:0] mem_model [logic [15:0]];
    logic [15:0] ref_mem   [logic [15:0]];

    int  errors, checks;
    int  ack_delay;
    bit  rand_mode;
    int  req_cnt, cur_delay;

    logic [15:0] acc_rdata;
    int          acc_cycles, acc_reqs;
    logic        acc_err;

    function automatic logic [15:0] mem_default(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    // Memory: acks a request on its (delay+1)-th cycle; never for a huge delay.
    initial begin
        logic [15:0] rd;
        mem_ack = 1'b0; mem_rdata = '0; req_cnt = 0; cur_delay = 0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (req_cnt == 0) cur_delay = rand_mode ? int'($urandom_range(0, 4)) : ack_delay;
                if (req_cnt == cur_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_model[mem_addr] = mem_wdata;
                        rd = mem_wdata;
                    end else begin
                        rd = mem_model.exists(mem_addr) ? mem_model[mem_addr] : mem_default(mem_addr);
                        mem_rdata = rd;
                    end
                    bus_log.push_back('{mem_we, mem_addr, rd});
                end else begin
                    mem_ack = 1'b0;
                end
                req_cnt++;
            end else begin
                mem_ack = 1'b0;
                req_cnt = 0;
            end
        end
    end

    task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [15:0] d);
        acc_cycles = 0; acc_reqs = 0; acc_err = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
        for (int i = 1; i <= 200; i++) begin
            #1;
            if (mem_req === 1'b1) acc_reqs++;
            if (cpu_ready === 1'b1) begin
                acc_cycles = i; acc_rdata = cpu_rdata; acc_err = cpu_error;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (acc_cycles == 0) begin
            errors++;
            $display("FAIL access_complete: addr=%h never got cpu_ready within 200 cycles", a);
            cpu_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        int busy;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_ready, cpu_rdata, cpu_error, wbuf_level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h rdy=%b rd=%h err=%b lvl=%0d required all zero",
                     mem_req, mem_we, mem_addr, mem_wdata, cpu_ready, cpu_rdata, cpu_error, wbuf_level);
        end
        @(negedge clk) reset = 1'b1;
        ack_delay = 100;
        for (int i = 0; i < 3; i++) cpu_access(1'b1, 16'h0020 + 16'(i), 16'h5500 + 16'(i));
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b1 || wbuf_level !== 3'd3) begin
            errors++;
            $display("FAIL reset_setup: got req=%b lvl=%0d required req=1 lvl=3", mem_req, wbuf_level);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || wbuf_level !== 3'd0 || cpu_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_midflight: got req=%b lvl=%0d err=%b required 0 0 0", mem_req, wbuf_level, cpu_error);
        end
        @(negedge clk) reset = 1'b1;
        busy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (mem_req !== 1'b0) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++;
            $display("FAIL reset_no_activity: got %0d busy cycles required 0", busy);
        end
    endtask

    task automatic test_posted();
        int acks, prev_lvl;
        bit prev_ack;
        ack_delay = 3;
        bus_log.delete();
        for (int i = 0; i < 4; i++) begin
            cpu_access(1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
            checks++;
            if (acc_cycles != 1) begin
                errors++;
                $display("FAIL posted_zero_wait[%0d]: got %0d cycles required 1", i, acc_cycles);
            end
        end
        checks++;
        if (wbuf_level !== 3'd4) begin
            errors++;
            $display("FAIL posted_level_full: got %0d required 4", wbuf_level);
        end
        cpu_access(1'b1, 16'h0014, 16'hA004);
        checks++;
        if (acc_cycles != 3) begin
            errors++;
            $display("FAIL full_with_pop_stall: got accepted on cycle %0d required 3", acc_cycles);
        end
        checks++;
        if (wbuf_level !== 3'd4) begin
            errors++;
            $display("FAIL full_with_pop_level: got %0d required 4", wbuf_level);
        end
        acks = 0; prev_ack = 1'b0; prev_lvl = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (prev_ack) begin
                checks++;
                if (wbuf_level !== 3'(prev_lvl - 1)) begin
                    errors++;
                    $display("FAIL posted_level_dec: got %0d required %0d", wbuf_level, prev_lvl - 1);
                end
            end
            prev_ack = (mem_ack === 1'b1);
            prev_lvl = int'(wbuf_level);
            if (prev_ack) acks++;
        end
        checks++;
        if (acks != 4 || wbuf_level !== 3'd0) begin
            errors++;
            $display("FAIL posted_drain: got acks=%0d lvl=%0d required acks=4 lvl=0", acks, wbuf_level);
        end
        checks++;
        if (bus_log.size() != 5) begin
            errors++;
            $display("FAIL posted_bus_count: got %0d required 5", bus_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (bus_log[i].we !== 1'b1 || bus_log[i].addr !== 16'h0010 + 16'(i) ||
                    bus_log[i].data !== 16'hA000 + 16'(i)) begin
                    errors++;
                    $display("FAIL posted_bus_order[%0d]: got we=%b a=%h d=%h required we=1 a=%h d=%h", i,
                             bus_log[i].we, bus_log[i].addr, bus_log[i].data, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
                end
            end
        end
    endtask

    task automatic test_raw();
        ack_delay = 1;
        bus_log.delete();
        cpu_access(1'b1, 16'h0040, 16'h1234);
        cpu_access(1'b0, 16'h0040, 16'h0000);
        checks++;
        if (acc_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL raw_rdata: got %h required 1234", acc_rdata);
        end
        checks++;
        if (cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_single_pulse: got cpu_ready=%b required 0", cpu_ready);
        end
        checks++;
        if (bus_log.size() != 2) begin
            errors++;
            $display("FAIL raw_bus_count: got %0d required 2", bus_log.size());
        end else begin
            checks++;
            if (bus_log[0].we !== 1'b1 || bus_log[0].addr !== 16'h0040 || bus_log[1].we !== 1'b0 ||
                bus_log[1].addr !== 16'h0040) begin
                errors++;
                $display("FAIL raw_bus_order: got (%b,%h) then (%b,%h) required write 0040 then read 0040",
                         bus_log[0].we, bus_log[0].addr, bus_log[1].we, bus_log[1].addr);
            end
        end
    endtask

    task automatic test_zero_wait();
        ack_delay = 0;
        mem_model[16'h0005] = 16'hBEEF;
        cpu_access(1'b0, 16'h0005, 16'h0000);
        checks++;
        if (acc_cycles != 3 || acc_rdata !== 16'hBEEF || acc_reqs != 1) begin
            errors++;
            $display("FAIL zero_wait_read: got cycle=%0d rdata=%h reqcyc=%0d required 3 BEEF 1",
                     acc_cycles, acc_rdata, acc_reqs);
        end
    endtask

    task automatic test_timeout();
        ack_delay = 1000;
        cpu_access(1'b0, 16'h0077, 16'h0000);
        checks++;
        if (acc_rdata !== 16'hFFFF || acc_err !== 1'b1 || acc_reqs != 8) begin
            errors++;
            $display("FAIL timeout_abort: got rdata=%h err=%b reqcyc=%0d required FFFF 1 8", acc_rdata, acc_err, acc_reqs);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cpu_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b required 1", cpu_error);
        end
        error_clr = 1'b1;
        @(posedge clk);
        #1 error_clr = 1'b0;
        checks++;
        if (cpu_error !== 1'b0) begin
            errors++;
            $display("FAIL error_clr: got %b required 0", cpu_error);
        end
        ack_delay = 7;
        cpu_access(1'b0, 16'h0077, 16'h0000);
        checks++;
        if (acc_rdata !== mem_default(16'h0077) || acc_err !== 1'b0 || cpu_error !== 1'b0 || acc_reqs != 8) begin
            errors++;
            $display("FAIL ack_beats_timeout: got rdata=%h err=%b reqcyc=%0d required %h 0 8",
                     acc_rdata, cpu_error, acc_reqs, mem_default(16'h0077));
        end
        ack_delay = 1000;
        error_clr = 1'b1;
        cpu_access(1'b0, 16'h0078, 16'h0000);
        error_clr = 1'b0;
        checks++;
        if (acc_err !== 1'b1 || acc_rdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL set_beats_clear: got err=%b rdata=%h required 1 FFFF", acc_err, acc_rdata);
        end
        checks++;
        if (cpu_error !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_set: got %b required 0", cpu_error);
        end
    endtask

    task automatic test_random();
        logic        wr;
        logic [15:0] a, d, exp;
        int          waited;
        rand_mode = 1'b1;
        bus_log.delete();
        exp_log.delete();
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 16'h0100 + 16'($urandom_range(0, 7));
            d  = 16'($urandom);
            cpu_access(wr, a, d);
            if (wr) begin
                ref_mem[a] = d;
                exp_log.push_back('{1'b1, a, d});
            end else begin
                exp = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
                exp_log.push_back('{1'b0, a, exp});
                checks++;
                if (acc_rdata !== exp) begin
                    errors++;
                    $display("FAIL random_read[%0d]: addr=%h got %h required %h", n, a, acc_rdata, exp);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waited = 0;
        while (waited < 200 && !(wbuf_level === 3'd0 && mem_req === 1'b0)) begin
            @(negedge clk); #1;
            waited++;
        end
        checks++;
        if (bus_log.size() != exp_log.size()) begin
            errors++;
            $display("FAIL random_bus_count: got %0d required %0d", bus_log.size(), exp_log.size());
        end else begin
            for (int i = 0; i < exp_log.size(); i++) begin
                checks++;
                if (bus_log[i].we !== exp_log[i].we || bus_log[i].addr !== exp_log[i].addr ||
                    bus_log[i].data !== exp_log[i].data) begin
                    errors++;
                    $display("FAIL random_bus_order[%0d]: got we=%b a=%h d=%h required we=%b a=%h d=%h", i,
                             bus_log[i].we, bus_log[i].addr, bus_log[i].data,
                             exp_log[i].we, exp_log[i].addr, exp_log[i].data);
                end
            end
        end
        checks++;
        if (cpu_error !== 1'b0) begin
            errors++;
            $display("FAIL random_no_error: got %b required 0", cpu_error);
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        error_clr = 1'b0; ack_delay = 0; rand_mode = 1'b0;
        acc_rdata = '0; acc_cycles = 0; acc_reqs = 0; acc_err = 1'b0;
        test_reset();
        test_posted();
        test_raw();
        test_zero_wait();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
